// File: rtl/matrix_pkg.sv
// Shared word width and FSM state encoding for the matrix stream I/O block.
package matrix_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      COMPUTE = 2'd2,
      DRAIN   = 2'd3
   } state_e;

endpackage

// File: rtl/matrix_stream_io_flat_word_select.sv
// Combinational word extractor: picks word idx_i out of a flat bus of
// WORDS words, each W bits, word 0 in the low bits. Out-of-range gives 0.
module flat_word_select #(
   parameter int WORDS = 4,
   parameter int W     = 32,
   parameter int IDX_W = 3
) (
   input  logic [WORDS*W-1:0] flat_i,
   input  logic [IDX_W-1:0]   idx_i,
   output logic [W-1:0]       word_o
);

   // Priority-free one-hot match on the index; only one i can hit.
   always_comb begin
      word_o = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (idx_i == IDX_W'(i)) word_o = flat_i[i*W +: W];
      end
   end

endmodule

// File: rtl/matrix_stream_io.sv
// Streams two n x n operand matrices in, hands them to an external
// multiplier, waits (bounded by TIMEOUT) for the product and streams it out.
module matrix_stream_io
   import matrix_pkg::*;
#(
   parameter int n       = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [WORD_W-1:0]       in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [WORD_W*n*n-1:0]   matrix_A,
   output logic [WORD_W*n*n-1:0]   matrix_B,
   output logic                    mul_reset,
   output logic                    mul_enable,
   input  logic [WORD_W*n*n-1:0]   mul_out,
   input  logic                    mul_out_ready,
   output logic [WORD_W-1:0]       out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    err
);

   localparam int NW    = n*n;
   localparam int IDX_W = $clog2(NW+1);
   localparam int CNT_W = $clog2(TIMEOUT+1);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW-1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT-1);

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    mul_reset_q, mul_reset_d;
   logic                    mul_enable_q, mul_enable_d;
   logic                    err_q, err_d;
   logic [WORD_W*NW-1:0]    a_q, b_q, result_q;
   logic                    wr_a, wr_b, cap;
   logic [WORD_W-1:0]       sel_word;

   // Handshake qualifiers come from registered state only.
   assign in_ready   = (state_q == LOAD_A) || (state_q == LOAD_B);
   assign out_valid  = (state_q == DRAIN);
   assign matrix_A   = a_q;
   assign matrix_B   = b_q;
   assign mul_reset  = mul_reset_q;
   assign mul_enable = mul_enable_q;
   assign err        = err_q;

   flat_word_select #(
      .WORDS (NW),
      .W     (WORD_W),
      .IDX_W (IDX_W)
   ) u_sel (
      .flat_i (result_q),
      .idx_i  (idx_q),
      .word_o (sel_word)
   );

   // Drive zero outside DRAIN so the bus is quiet when nothing is offered.
   assign out_data = out_valid ? sel_word : '0;

   // Next-state, index, timeout counter and register-write strobes.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      mul_reset_d  = mul_reset_q;
      mul_enable_d = mul_enable_q;
      err_d        = err_q;
      wr_a         = 1'b0;
      wr_b         = 1'b0;
      cap          = 1'b0;
      case (state_q)
         LOAD_A: begin
            if (in_valid) begin
               wr_a = 1'b1;
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = LOAD_B;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         LOAD_B: begin
            if (in_valid) begin
               wr_b = 1'b1;
               if (idx_q == LAST_IDX) begin
                  idx_d        = '0;
                  cnt_d        = '0;
                  mul_reset_d  = 1'b0;
                  mul_enable_d = 1'b1;
                  state_d      = COMPUTE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         COMPUTE: begin
            // A product arriving on the last allowed cycle still wins.
            if (mul_out_ready) begin
               cap          = 1'b1;
               mul_reset_d  = 1'b1;
               mul_enable_d = 1'b0;
               idx_d        = '0;
               cnt_d        = '0;
               state_d      = DRAIN;
            end else if (cnt_q == CNT_LAST) begin
               err_d        = 1'b1;
               mul_reset_d  = 1'b1;
               mul_enable_d = 1'b0;
               idx_d        = '0;
               cnt_d        = '0;
               state_d      = LOAD_A;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  idx_d   = '0;
                  state_d = LOAD_A;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = LOAD_A;
            idx_d   = '0;
         end
      endcase
   end

   // State, control flags and matrix storage; reset wins in every state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= LOAD_A;
         idx_q        <= '0;
         cnt_q        <= '0;
         mul_reset_q  <= 1'b1;
         mul_enable_q <= 1'b0;
         err_q        <= 1'b0;
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         mul_reset_q  <= mul_reset_d;
         mul_enable_q <= mul_enable_d;
         err_q        <= err_d;
         if (wr_a) a_q[idx_q*WORD_W +: WORD_W] <= in_data;
         if (wr_b) b_q[idx_q*WORD_W +: WORD_W] <= in_data;
         if (cap)  result_q <= mul_out;
      end
   end

endmodule

// File: tb/tb_matrix_stream_io.sv
// Bench for matrix_stream_io at n=2, TIMEOUT=16. Inputs are driven and
// outputs sampled on the falling edge; a matrix-product model supplies the
// multiplier response and the expected output stream.
module tb_matrix_stream_io;

   localparam int N  = 2;
   localparam int NW = N*N;
   localparam int TO = 16;

   logic              clk;
   logic              reset;
   logic [31:0]       in_data;
   logic              in_valid;
   logic              in_ready;
   logic [32*NW-1:0]  matrix_A;
   logic [32*NW-1:0]  matrix_B;
   logic              mul_reset;
   logic              mul_enable;
   logic [32*NW-1:0]  mul_out;
   logic              mul_out_ready;
   logic [31:0]       out_data;
   logic              out_valid;
   logic              out_ready;
   logic              err;

   int ntests = 0;
   int nfail  = 0;
   int acc_cnt = 0;

   logic [31:0] am [NW];
   logic [31:0] bm [NW];
   logic [31:0] pm [NW];

   matrix_stream_io #(.n(N), .TIMEOUT(TO)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .matrix_A      (matrix_A),
      .matrix_B      (matrix_B),
      .mul_reset     (mul_reset),
      .mul_enable    (mul_enable),
      .mul_out       (mul_out),
      .mul_out_ready (mul_out_ready),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .err           (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Independent count of input handshakes.
   always @(posedge clk) begin
      if (!reset && in_valid && in_ready) acc_cnt <= acc_cnt + 1;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [32*NW-1:0] pack4(input logic [31:0] w [NW]);
      logic [32*NW-1:0] r;
      r = '0;
      for (int i = 0; i < NW; i++) r[i*32 +: 32] = w[i];
      return r;
   endfunction

   // Reference product, row-major, modulo 2^32.
   task automatic model_matmul();
      for (int r = 0; r < N; r++) begin
         for (int c = 0; c < N; c++) begin
            logic [31:0] s;
            s = 32'd0;
            for (int k = 0; k < N; k++) s = s + am[r*N+k] * bm[k*N+c];
            pm[r*N+c] = s;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      mul_out_ready = 1'b0;
      mul_out = '0;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // Offer one word; returns at the falling edge after it was accepted.
   task automatic send_word(input logic [31:0] d, input bit gap);
      int w;
      if (gap) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = d;
      w = 0;
      while (!in_ready && w < 40) begin
         @(negedge clk);
         w++;
      end
      if (!in_ready) begin
         ntests++; nfail++;
         $display("FAIL send_wait: in_ready=%0b required 1", in_ready);
      end
      @(negedge clk);
   endtask

   task automatic load_ab(input bit gapped);
      for (int i = 0; i < NW; i++) send_word(am[i], gapped);
      for (int i = 0; i < NW; i++) send_word(bm[i], gapped);
      in_valid = 1'b0;
   endtask

   // Present pm as the product after 'dly' COMPUTE cycles with a 1-cycle pulse.
   task automatic finish_compute(input int dly);
      mul_out = pack4(pm);
      repeat (dly) @(negedge clk);
      mul_out_ready = 1'b1;
      @(negedge clk);
      mul_out_ready = 1'b0;
      mul_out = '0;
      ntests++;
      if (out_valid !== 1'b1 || mul_reset !== 1'b1 || mul_enable !== 1'b0) begin
         nfail++;
         $display("FAIL enter_drain: valid/mrst/men=%0b%0b%0b required 110",
                  out_valid, mul_reset, mul_enable);
      end
   endtask

   // Consume the product stream, stalling stall_len cycles before word stall_k.
   task automatic drain_stream(input int stall_k, input int stall_len, input bit rnd);
      for (int k = 0; k < NW; k++) begin
         int s;
         s = (k == stall_k) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
         for (int j = 0; j < s; j++) begin
            out_ready = 1'b0;
            ntests++;
            if (out_valid !== 1'b1 || out_data !== pm[k]) begin
               nfail++;
               $display("FAIL drain_stall[%0d]: valid=%0b data=%0h required 1/%0h",
                        k, out_valid, out_data, pm[k]);
            end
            @(negedge clk);
         end
         out_ready = 1'b1;
         ntests++;
         if (out_valid !== 1'b1 || out_data !== pm[k]) begin
            nfail++;
            $display("FAIL drain_word[%0d]: valid=%0b data=%0h required 1/%0h",
                     k, out_valid, out_data, pm[k]);
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
      ntests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         nfail++;
         $display("FAIL drain_end: valid=%0b in_ready=%0b required 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      do_reset();
      ntests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'd0) begin
         nfail++;
         $display("FAIL reset_hs: in_ready=%0b out_valid=%0b out_data=%0h required 1/0/0",
                  in_ready, out_valid, out_data);
      end
      ntests++;
      if (mul_reset !== 1'b1 || mul_enable !== 1'b0 || err !== 1'b0) begin
         nfail++;
         $display("FAIL reset_ctl: mrst=%0b men=%0b err=%0b required 1/0/0",
                  mul_reset, mul_enable, err);
      end
      ntests++;
      if (matrix_A !== '0 || matrix_B !== '0) begin
         nfail++;
         $display("FAIL reset_mat: A=%0h B=%0h required 0", matrix_A, matrix_B);
      end
   endtask

   task automatic test_load();
      int a0;
      am = '{32'd1, 32'd0, 32'd1, 32'd1};
      bm = '{32'd1, 32'd0, 32'd1, 32'd1};
      a0 = acc_cnt;
      load_ab(1'b0);
      ntests++;
      if (acc_cnt - a0 !== 8) begin
         nfail++;
         $display("FAIL load_accepts: got %0d required 8", acc_cnt - a0);
      end
      ntests++;
      if (matrix_A[31:0] !== 32'd1 || matrix_A[63:32] !== 32'd0 ||
          matrix_A[95:64] !== 32'd1 || matrix_A[127:96] !== 32'd1) begin
         nfail++;
         $display("FAIL load_A: got %0h required %0h", matrix_A, pack4(am));
      end
      ntests++;
      if (matrix_B !== pack4(bm)) begin
         nfail++;
         $display("FAIL load_B: got %0h required %0h", matrix_B, pack4(bm));
      end
      ntests++;
      if (mul_reset !== 1'b0 || mul_enable !== 1'b1 || in_ready !== 1'b0) begin
         nfail++;
         $display("FAIL load_compute: mrst=%0b men=%0b in_ready=%0b required 0/1/0",
                  mul_reset, mul_enable, in_ready);
      end
      model_matmul();
      finish_compute(2);
      drain_stream(-1, 0, 1'b0);
   endtask

   task automatic test_gapped();
      for (int rep = 0; rep < 3; rep++) begin
         for (int i = 0; i < NW; i++) begin
            am[i] = $urandom;
            bm[i] = $urandom;
         end
         load_ab(1'b1);
         ntests++;
         if (matrix_A !== pack4(am) || matrix_B !== pack4(bm)) begin
            nfail++;
            $display("FAIL gapped_mat[%0d]: A=%0h B=%0h required %0h/%0h",
                     rep, matrix_A, matrix_B, pack4(am), pack4(bm));
         end
         model_matmul();
         finish_compute(int'($urandom_range(0, 8)));
         drain_stream(-1, 0, 1'b1);
      end
   endtask

   task automatic test_drain_stall();
      am = '{32'd3, 32'd4, 32'd5, 32'd6};
      bm = '{32'd7, 32'd8, 32'd9, 32'd10};
      load_ab(1'b0);
      pm = '{32'd1, 32'd0, 32'd2, 32'd1};
      finish_compute(1);
      drain_stream(2, 3, 1'b0);
   endtask

   task automatic test_timeout();
      // Product strobes and sink readiness are meaningless while loading.
      mul_out_ready = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(negedge clk);
      ntests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || mul_enable !== 1'b0) begin
         nfail++;
         $display("FAIL ignore_mor: in_ready=%0b out_valid=%0b men=%0b required 1/0/0",
                  in_ready, out_valid, mul_enable);
      end
      mul_out_ready = 1'b0;
      out_ready = 1'b0;
      for (int i = 0; i < NW; i++) begin
         am[i] = $urandom;
         bm[i] = $urandom;
      end
      load_ab(1'b0);
      in_valid = 1'b1;
      in_data = 32'hDEAD_BEEF;
      repeat (TO-1) @(negedge clk);
      ntests++;
      if (err !== 1'b0 || in_ready !== 1'b0 || mul_enable !== 1'b1) begin
         nfail++;
         $display("FAIL timeout_early: err=%0b in_ready=%0b men=%0b required 0/0/1",
                  err, in_ready, mul_enable);
      end
      ntests++;
      if (matrix_A !== pack4(am) || matrix_B !== pack4(bm)) begin
         nfail++;
         $display("FAIL compute_hold: A=%0h B=%0h required %0h/%0h",
                  matrix_A, matrix_B, pack4(am), pack4(bm));
      end
      in_valid = 1'b0;
      @(negedge clk);
      ntests++;
      if (err !== 1'b1 || mul_reset !== 1'b1 || mul_enable !== 1'b0 ||
          in_ready !== 1'b1 || out_valid !== 1'b0) begin
         nfail++;
         $display("FAIL timeout: err=%0b mrst=%0b men=%0b in_ready=%0b valid=%0b required 1/1/0/1/0",
                  err, mul_reset, mul_enable, in_ready, out_valid);
      end
      // A clean transaction afterwards must leave err set.
      for (int i = 0; i < NW; i++) begin
         am[i] = $urandom_range(0, 255);
         bm[i] = $urandom_range(0, 255);
      end
      load_ab(1'b1);
      model_matmul();
      finish_compute(3);
      drain_stream(1, 1, 1'b0);
      ntests++;
      if (err !== 1'b1) begin
         nfail++;
         $display("FAIL err_sticky: got %0b required 1", err);
      end
   endtask

   task automatic test_reset_mid_drain();
      for (int i = 0; i < NW; i++) begin
         am[i] = $urandom;
         bm[i] = $urandom;
      end
      load_ab(1'b0);
      model_matmul();
      finish_compute(0);
      out_ready = 1'b1;
      repeat (2) @(negedge clk);
      out_ready = 1'b0;
      ntests++;
      if (out_valid !== 1'b1 || out_data !== pm[2]) begin
         nfail++;
         $display("FAIL mid_drain: valid=%0b data=%0h required 1/%0h", out_valid, out_data, pm[2]);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      ntests++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 32'd0) begin
         nfail++;
         $display("FAIL rst_drain_hs: valid=%0b in_ready=%0b data=%0h required 0/1/0",
                  out_valid, in_ready, out_data);
      end
      ntests++;
      if (dut.result_q !== '0 || matrix_A !== '0 || matrix_B !== '0 ||
          err !== 1'b0 || mul_reset !== 1'b1) begin
         nfail++;
         $display("FAIL rst_drain_regs: result=%0h A=%0h err=%0b mrst=%0b required 0/0/0/1",
                  dut.result_q, matrix_A, err, mul_reset);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_gapped();
      test_drain_stall();
      test_timeout();
      test_reset_mid_drain();
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
